// File: rtl/pipelined_exec_core.sv
// pipelined_exec_core: three-stage RV32I integer execute pipeline (ID -> EX -> WB).
// Instruction words arrive on a valid/ready stream. Retired results leave through a
// valid/ready stream. The core handles OP, OP-IMM and LUI, and resolves RAW hazards
// either by forwarding from EX/WB or by stalling ID.
module pipelined_exec_core #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter bit FWD_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_rd,
  output logic             out_wen,
  output logic             out_illegal
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int SH_W  = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } alu_op_e;

  // Map funct3 (+ alternate bit for SUB/SRA) to an ALU operation.
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? OP_SUB : OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = alt ? OP_SRA : OP_SRL;
      3'b110:  op = OP_OR;
      3'b111:  op = OP_AND;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

  // Integer ALU; shifts use the low log2(WIDTH) bits of operand b.
  function automatic logic [WIDTH-1:0] alu(input alu_op_e op, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [SH_W-1:0]  sh;
    logic [WIDTH-1:0] r;
    sh = b[SH_W-1:0];
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLL:  r = a << sh;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  r = a ^ b;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $unsigned($signed(a) >>> sh);
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Sign-extend a 32-bit value to the datapath width.
  function automatic logic [WIDTH-1:0] sext32(input logic [31:0] v);
    logic [WIDTH-1:0] r;
    r = {WIDTH{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // Pipeline state
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic             id_valid_q, id_valid_d;
  logic [31:0]      id_instr_q, id_instr_d;
  logic             ex_valid_q, ex_valid_d, ex_wen_q, ex_wen_d, ex_ill_q, ex_ill_d;
  alu_op_e          ex_op_q, ex_op_d;
  logic [WIDTH-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             wb_valid_q, wb_valid_d, wb_wen_q, wb_wen_d, wb_ill_q, wb_ill_d;
  logic [WIDTH-1:0] wb_res_q, wb_res_d;
  logic [4:0]       wb_rd_q, wb_rd_d;

  // Decode / control signals
  logic [4:0]       rd_s, rs1_s, rs2_s;
  logic             use_rs1_s, use_rs2_s, imm_sel_s, lui_s, ill_s, dec_wen_s;
  alu_op_e          dec_op_s;
  logic [WIDTH-1:0] rf1_s, rf2_s, opa_s, opb_s, ex_res_s;
  logic             stall_s, hazard_s, id_adv_s, wb_fire_s;

  assign rd_s  = id_instr_q[11:7];
  assign rs1_s = id_instr_q[19:15];
  assign rs2_s = id_instr_q[24:20];

  // Decode the ID-stage word: operation, operand usage and legality.
  always_comb begin
    dec_op_s  = OP_ADD;
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    imm_sel_s = 1'b0;
    lui_s     = 1'b0;
    ill_s     = 1'b0;
    case (id_instr_q[6:0])
      7'b0110011: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        dec_op_s  = f3_to_op(id_instr_q[14:12], id_instr_q[30]);
        if (id_instr_q[31:25] == 7'b0000000) begin
          ill_s = 1'b0;
        end else if (id_instr_q[31:25] == 7'b0100000 &&
                     (id_instr_q[14:12] == 3'b000 || id_instr_q[14:12] == 3'b101)) begin
          ill_s = 1'b0;
        end else begin
          ill_s = 1'b1;
        end
      end
      7'b0010011: begin
        use_rs1_s = 1'b1;
        imm_sel_s = 1'b1;
        dec_op_s  = f3_to_op(id_instr_q[14:12],
                             (id_instr_q[14:12] == 3'b101) && id_instr_q[30]);
      end
      7'b0110111: lui_s = 1'b1;
      default:    ill_s = 1'b1;
    endcase
    if (int'(rd_s) >= NUM_REGS ||
        (use_rs1_s && int'(rs1_s) >= NUM_REGS) ||
        (use_rs2_s && int'(rs2_s) >= NUM_REGS)) begin
      ill_s = 1'b1;
    end else begin
      ill_s = ill_s;
    end
    dec_wen_s = !ill_s && (rd_s != 5'd0);
  end

  // Operand fetch with optional EX/WB bypass; x0 is never bypassed.
  always_comb begin
    rf1_s = (int'(rs1_s) < NUM_REGS) ? regs_q[rs1_s[IDX_W-1:0]] : {WIDTH{1'b0}};
    rf2_s = (int'(rs2_s) < NUM_REGS) ? regs_q[rs2_s[IDX_W-1:0]] : {WIDTH{1'b0}};
    opa_s = rf1_s;
    opb_s = rf2_s;
    if (FWD_EN && rs1_s != 5'd0 && ex_valid_q && ex_wen_q && ex_rd_q == rs1_s) begin
      opa_s = ex_res_s;
    end else if (FWD_EN && rs1_s != 5'd0 && wb_valid_q && wb_wen_q && wb_rd_q == rs1_s) begin
      opa_s = wb_res_q;
    end else begin
      opa_s = rf1_s;
    end
    if (FWD_EN && rs2_s != 5'd0 && ex_valid_q && ex_wen_q && ex_rd_q == rs2_s) begin
      opb_s = ex_res_s;
    end else if (FWD_EN && rs2_s != 5'd0 && wb_valid_q && wb_wen_q && wb_rd_q == rs2_s) begin
      opb_s = wb_res_q;
    end else begin
      opb_s = rf2_s;
    end
  end

  // Hazard detection, stall/advance control and stream handshakes.
  always_comb begin
    stall_s  = wb_valid_q && !out_ready;
    hazard_s = !FWD_EN && id_valid_q && !ill_s && (
      (use_rs1_s && rs1_s != 5'd0 &&
        ((ex_valid_q && ex_wen_q && ex_rd_q == rs1_s) ||
         (wb_valid_q && wb_wen_q && wb_rd_q == rs1_s))) ||
      (use_rs2_s && rs2_s != 5'd0 &&
        ((ex_valid_q && ex_wen_q && ex_rd_q == rs2_s) ||
         (wb_valid_q && wb_wen_q && wb_rd_q == rs2_s))));
    id_adv_s  = id_valid_q && !stall_s && !hazard_s;
    in_ready  = !id_valid_q || id_adv_s;
    wb_fire_s = wb_valid_q && out_ready && wb_wen_q;
    ex_res_s  = ex_ill_q ? {WIDTH{1'b0}} : alu(ex_op_q, ex_a_q, ex_b_q);
  end

  // Next-state for the three pipeline stages.
  always_comb begin
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    ex_valid_d = ex_valid_q; ex_op_d = ex_op_q; ex_a_d = ex_a_q; ex_b_d = ex_b_q;
    ex_rd_d    = ex_rd_q;    ex_wen_d = ex_wen_q; ex_ill_d = ex_ill_q;
    wb_valid_d = wb_valid_q; wb_res_d = wb_res_q; wb_rd_d = wb_rd_q;
    wb_wen_d   = wb_wen_q;   wb_ill_d = wb_ill_q;
    if (in_valid && in_ready) begin
      id_valid_d = 1'b1;
      id_instr_d = in_instr;
    end else if (id_adv_s) begin
      id_valid_d = 1'b0;
    end else begin
      id_valid_d = id_valid_q;
    end
    if (!stall_s) begin
      ex_valid_d = id_adv_s;
      ex_op_d    = lui_s ? OP_ADD : dec_op_s;
      ex_a_d     = lui_s ? {WIDTH{1'b0}} : opa_s;
      ex_b_d     = lui_s     ? sext32({id_instr_q[31:12], 12'h000}) :
                   imm_sel_s ? sext32({{20{id_instr_q[31]}}, id_instr_q[31:20]}) : opb_s;
      ex_rd_d    = rd_s;
      ex_wen_d   = id_adv_s && dec_wen_s;
      ex_ill_d   = id_adv_s && ill_s;
      wb_valid_d = ex_valid_q;
      wb_res_d   = ex_valid_q ? ex_res_s : {WIDTH{1'b0}};
      wb_rd_d    = ex_valid_q ? ex_rd_q : 5'd0;
      wb_wen_d   = ex_valid_q && ex_wen_q;
      wb_ill_d   = ex_valid_q && ex_ill_q;
    end else begin
      ex_valid_d = ex_valid_q;
      wb_valid_d = wb_valid_q;
    end
  end

  // Pipeline registers with asynchronous reset discarding in-flight work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid_q <= 1'b0; id_instr_q <= 32'h0000_0000;
      ex_valid_q <= 1'b0; ex_op_q <= OP_ADD; ex_a_q <= {WIDTH{1'b0}}; ex_b_q <= {WIDTH{1'b0}};
      ex_rd_q    <= 5'd0; ex_wen_q <= 1'b0;  ex_ill_q <= 1'b0;
      wb_valid_q <= 1'b0; wb_res_q <= {WIDTH{1'b0}}; wb_rd_q <= 5'd0;
      wb_wen_q   <= 1'b0; wb_ill_q <= 1'b0;
    end else begin
      id_valid_q <= id_valid_d; id_instr_q <= id_instr_d;
      ex_valid_q <= ex_valid_d; ex_op_q <= ex_op_d; ex_a_q <= ex_a_d; ex_b_q <= ex_b_d;
      ex_rd_q    <= ex_rd_d;    ex_wen_q <= ex_wen_d; ex_ill_q <= ex_ill_d;
      wb_valid_q <= wb_valid_d; wb_res_q <= wb_res_d; wb_rd_q <= wb_rd_d;
      wb_wen_q   <= wb_wen_d;   wb_ill_q <= wb_ill_d;
    end
  end

  // Register file: written only when the WB result is actually consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= {WIDTH{1'b0}};
    end else if (wb_fire_s) begin
      regs_q[wb_rd_q[IDX_W-1:0]] <= wb_res_q;
    end
  end

  assign out_valid   = wb_valid_q;
  assign out_result  = wb_res_q;
  assign out_rd      = wb_rd_q;
  assign out_wen     = wb_wen_q;
  assign out_illegal = wb_ill_q;

endmodule

// File: tb/tb_pipelined_exec_core.sv
// Bench for pipelined_exec_core: directed instruction stream with a result scoreboard.
// Instance a uses forwarding with 32 registers; instance b stalls on hazards with 16 registers.
module tb_pipelined_exec_core;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
  logic [31:0] a_in_instr = 32'h0, a_out_result;
  logic [4:0]  a_out_rd;
  logic        a_out_wen, a_out_illegal;
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
  logic [31:0] b_in_instr = 32'h0, b_out_result;
  logic [4:0]  b_out_rd;
  logic        b_out_wen, b_out_illegal;

  int   total = 0;
  int   bad = 0;
  int   w;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  pipelined_exec_core #(.WIDTH(32), .NUM_REGS(32), .FWD_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_out_result),
    .out_rd(a_out_rd), .out_wen(a_out_wen), .out_illegal(a_out_illegal));

  pipelined_exec_core #(.WIDTH(32), .NUM_REGS(16), .FWD_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
    .out_rd(b_out_rd), .out_wen(b_out_wen), .out_illegal(b_out_illegal));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic void push(input int sel, input logic [31:0] r, input logic [4:0] rd,
      input logic wen, input logic ill);
    exp_t e;
    e.res = r; e.rd = rd; e.wen = wen; e.ill = ill;
    if (sel == 0) qa.push_back(e);
    else qb.push_back(e);
  endfunction

  // Offer one word (called 1 time unit after a rising edge); returns cycles waited.
  task automatic send(input int sel, input logic [31:0] ins, output int waits);
    int n;
    n = 0;
    if (sel == 0) begin a_in_valid = 1'b1; a_in_instr = ins; end
    else begin b_in_valid = 1'b1; b_in_instr = ins; end
    #1;
    while (((sel == 0) ? a_in_ready : b_in_ready) == 1'b0 && n < 100) begin
      @(posedge clk); #2; n++;
    end
    chk("accept_timeout", 64'(n < 100), 64'd1);
    @(posedge clk); #1;
    if (sel == 0) a_in_valid = 1'b0;
    else b_in_valid = 1'b0;
    waits = n;
  endtask

  task automatic drain(input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? qa.size() : qb.size()) != 0 && n < 60) begin
      @(negedge clk); n++;
    end
    chk("drain", 64'((sel == 0) ? qa.size() : qb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboard for instance a: compare every consumed result with the oldest expectation.
  always @(negedge clk) begin
    if (rst && a_out_valid && a_out_ready) begin
      chk("a_unexpected", 64'(qa.size() != 0), 64'd1);
      if (qa.size() != 0) begin
        exp_t e;
        e = qa.pop_front();
        chk("a_result", 64'(a_out_result), 64'(e.res));
        chk("a_rd", 64'(a_out_rd), 64'(e.rd));
        chk("a_wen", 64'(a_out_wen), 64'(e.wen));
        chk("a_illegal", 64'(a_out_illegal), 64'(e.ill));
      end
    end
  end

  // Scoreboard for instance b.
  always @(negedge clk) begin
    if (rst && b_out_valid && b_out_ready) begin
      chk("b_unexpected", 64'(qb.size() != 0), 64'd1);
      if (qb.size() != 0) begin
        exp_t e;
        e = qb.pop_front();
        chk("b_result", 64'(b_out_result), 64'(e.res));
        chk("b_rd", 64'(b_out_rd), 64'(e.rd));
        chk("b_wen", 64'(b_out_wen), 64'(e.wen));
        chk("b_illegal", 64'(b_out_illegal), 64'(e.ill));
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_out_result", 64'(a_out_result), 64'd0);
    chk("rst_out_wen", 64'(a_out_wen), 64'd0);
    chk("rst_out_illegal", 64'(a_out_illegal), 64'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    // Latency: ADDI x1,x0,5 retires after the accept edge plus two more edges
    push(0, 32'd5, 5'd1, 1'b1, 1'b0);
    send(0, 32'h0050_0093, w);
    chk("lat_id", 64'(a_out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_ex", 64'(a_out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_wb_valid", 64'(a_out_valid), 64'd1);
    chk("lat_wb_result", 64'(a_out_result), 64'd5);

    // Forwarding: back-to-back dependent pair, results on consecutive cycles
    push(0, 32'd5, 5'd1, 1'b1, 1'b0);
    send(0, 32'h0050_0093, w);
    push(0, 32'd10, 5'd2, 1'b1, 1'b0);
    send(0, 32'h0010_8133, w);
    chk("fwd_no_wait", 64'(w), 64'd0);
    @(posedge clk); #1;
    chk("fwd_first", 64'(a_out_result), 64'd5);
    @(posedge clk); #1;
    chk("fwd_second_valid", 64'(a_out_valid), 64'd1);
    chk("fwd_second", 64'(a_out_result), 64'd10);
    drain(0);

    // ALU operations, shifts, compares, LUI, illegal funct7
    push(0, 32'hFFFF_FFFF, 5'd3, 1'b1, 1'b0);  send(0, 32'hFFF0_0193, w);
    push(0, 32'hFFFF_FFFF, 5'd4, 1'b1, 1'b0);  send(0, enc_i(12'h404, 5'd3, 3'b101, 5'd4), w);
    push(0, 32'h0000_000F, 5'd5, 1'b1, 1'b0);  send(0, enc_i(12'd28, 5'd3, 3'b101, 5'd5), w);
    push(0, 32'd1, 5'd7, 1'b1, 1'b0);  send(0, enc_r(7'h00, 5'd1, 5'd3, 3'b010, 5'd7), w);
    push(0, 32'd0, 5'd8, 1'b1, 1'b0);  send(0, enc_r(7'h00, 5'd1, 5'd3, 3'b011, 5'd8), w);
    push(0, 32'd6, 5'd9, 1'b1, 1'b0);  send(0, enc_r(7'h20, 5'd3, 5'd1, 3'b000, 5'd9), w);
    push(0, 32'hFFFF_FFFA, 5'd10, 1'b1, 1'b0); send(0, enc_r(7'h00, 5'd3, 5'd1, 3'b100, 5'd10), w);
    push(0, 32'h8000_0000, 5'd11, 1'b1, 1'b0); send(0, {20'h80000, 5'd11, 7'b0110111}, w);
    push(0, 32'h0000_00A0, 5'd12, 1'b1, 1'b0); send(0, enc_r(7'h00, 5'd1, 5'd1, 3'b001, 5'd12), w);
    push(0, 32'd4, 5'd13, 1'b1, 1'b0); send(0, enc_r(7'h00, 5'd1, 5'd3, 3'b000, 5'd13), w);
    push(0, 32'd0, 5'd15, 1'b0, 1'b1); send(0, enc_r(7'h01, 5'd1, 5'd1, 3'b000, 5'd15), w);
    drain(0);

    // Backpressure: three words fill the pipe, the fourth waits, outputs hold
    a_out_ready = 1'b0;
    push(0, 32'd1, 5'd16, 1'b1, 1'b0); send(0, enc_i(12'd1, 5'd0, 3'b000, 5'd16), w);
    push(0, 32'd2, 5'd17, 1'b1, 1'b0); send(0, enc_i(12'd1, 5'd16, 3'b000, 5'd17), w);
    push(0, 32'd3, 5'd18, 1'b1, 1'b0); send(0, enc_i(12'd1, 5'd17, 3'b000, 5'd18), w);
    chk("bp_third_no_wait", 64'(w), 64'd0);
    a_in_valid = 1'b1; a_in_instr = enc_r(7'h00, 5'd16, 5'd18, 3'b000, 5'd19);
    #1;
    chk("bp_in_ready_low", 64'(a_in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 64'(a_out_valid), 64'd1);
      chk("bp_hold_result", 64'(a_out_result), 64'd1);
      chk("bp_hold_rd", 64'(a_out_rd), 64'd16);
      chk("bp_hold_ready", 64'(a_in_ready), 64'd0);
    end
    a_out_ready = 1'b1;
    push(0, 32'd4, 5'd19, 1'b1, 1'b0);
    send(0, enc_r(7'h00, 5'd16, 5'd18, 3'b000, 5'd19), w);
    drain(0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_no_extra", 64'(a_out_valid), 64'd0);

    // x0 destination, x0 reads, undecodable opcode
    push(0, 32'd7, 5'd0, 1'b0, 1'b0); send(0, enc_i(12'd7, 5'd0, 3'b000, 5'd0), w);
    push(0, 32'd0, 5'd6, 1'b1, 1'b0); send(0, enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd6), w);
    push(0, 32'd0, 5'd0, 1'b0, 1'b1); send(0, 32'h0000_007F, w);
    drain(0);

    // Stall-on-hazard instance: dependent pair separated by two bubbles
    push(1, 32'd5, 5'd1, 1'b1, 1'b0);  send(1, 32'h0050_0093, w);
    push(1, 32'd10, 5'd2, 1'b1, 1'b0); send(1, 32'h0010_8133, w);
    chk("stl_ready_low1", 64'(b_in_ready), 64'd0);
    @(posedge clk); #1;
    chk("stl_first", 64'(b_out_result), 64'd5);
    chk("stl_ready_low2", 64'(b_in_ready), 64'd0);
    @(posedge clk); #1;
    chk("stl_bubble1", 64'(b_out_valid), 64'd0);
    chk("stl_ready_back", 64'(b_in_ready), 64'd1);
    @(posedge clk); #1;
    chk("stl_bubble2", 64'(b_out_valid), 64'd0);
    @(posedge clk); #1;
    chk("stl_second_valid", 64'(b_out_valid), 64'd1);
    chk("stl_second", 64'(b_out_result), 64'd10);
    // rd beyond the 16-entry register file is illegal
    push(1, 32'd0, 5'd20, 1'b0, 1'b1); send(1, enc_i(12'd1, 5'd0, 3'b000, 5'd20), w);
    drain(1);

    // Asynchronous reset with three instructions in flight
    send(0, enc_i(12'd9, 5'd0, 3'b000, 5'd1), w);
    send(0, enc_i(12'd9, 5'd0, 3'b000, 5'd2), w);
    send(0, enc_i(12'd9, 5'd0, 3'b000, 5'd3), w);
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 64'(a_out_valid), 64'd0);
    chk("arst_in_ready", 64'(a_in_ready), 64'd1);
    chk("arst_out_result", 64'(a_out_result), 64'd0);
    qa.delete();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    push(0, 32'd0, 5'd15, 1'b1, 1'b0);
    send(0, enc_r(7'h00, 5'd0, 5'd1, 3'b000, 5'd15), w);
    drain(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_exec_core.md
Name: pipelined_exec_core

Overview:
Parametrised three-stage integer execute pipeline (ID -> EX -> WB) for the RISC-V datapath. It accepts 32-bit instruction words over a valid/ready stream rather than an internal program memory. Supports RV32I OP/OP-IMM/LUI with sign-extended immediates and selectable operand forwarding or stall-on-hazard. It streams retired results out with backpressure.

Parameters:
WIDTH, 32, datapath/register width in bits (must be >= 32)
NUM_REGS, 32, architectural registers (2..32); x0 hardwired to zero
FWD_EN, 1, 1 = forward from EX and WB into ID; 0 = stall ID on RAW hazard

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  instruction word present
in_ready  out  1  core accepts word this cycle
in_instr  in  32  instruction word
out_valid  out  1  WB stage holds a retired result
out_ready  in  1  consumer accepts result
out_result  out  WIDTH  ALU/LUI result
out_rd  out  5  destination register field
out_wen  out  1  result written to register file (legal and rd != 0)
out_illegal  out  1  instruction was not decodable

Behaviour:
- Reset (rst low, async): ID/EX/WB valid bits cleared, all registers cleared to 0, out_valid=0, out_result=0, out_rd=0, out_wen=0, out_illegal=0, in_ready=1. In-flight instructions are discarded.
- Accept on in_valid && in_ready. Latency: accepted at edge N -> ID in cycle N+1 -> EX in N+2 -> out_valid in N+3. Throughput is 1 per cycle with no stalls.
- Global stall: out_valid && !out_ready. All three stages hold. While stalled, out_* stay stable and no register-file write occurs.
- Register write occurs at the edge where WB fires (out_valid && out_ready && out_wen). Reads return the pre-write value in that same cycle.
- in_ready = !id_valid || (ID advances this cycle).
- Operand source in ID, priority order:
  - FWD_EN=1: EX-stage ALU output if EX valid, EX wen, and rd==rs; else WB register if WB valid, WB wen, and rd==rs; else register file. Forwarding never applies for rs==0.
  - FWD_EN=0: ID holds and a bubble is inserted into EX while any valid EX or WB entry with wen has rd equal to a nonzero rs1/rs2 used by the instruction.
- Decode:
  - opcode 0110011 (R): funct3 000 ADD/SUB (SUB when funct7=0100000), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (SRA when funct7=0100000), 110 OR, 111 AND. Any other funct7 is illegal.
  - opcode 0010011 (I): same ops with imm=instr[31:20] sign-extended to WIDTH; no SUB form. SLLI/SRLI/SRAI select via instr[30].
  - opcode 0110111 (LUI): result = {instr[31:12],12'b0} sign-extended to WIDTH. rs1/rs2 unused, so no hazard.
- Shift amount = low $clog2(WIDTH) bits of operand 2. SLT is signed and SLTU unsigned; result is 0 or 1 zero-extended. Add/sub wrap modulo 2^WIDTH.
- Illegal cases: unknown opcode, illegal funct7, or rd/rs >= NUM_REGS. The instruction still flows through the pipe with out_illegal=1, out_wen=0, out_result=0; it never stalls or forwards.
- rd==0 on a legal instruction: result is produced with out_wen=0, and x0 remains 0.
- Simultaneous accept, stall, and WB fire are resolved in one cycle. A stage may load a new entry in the same cycle its occupant advances.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) with out_ready=1 -> out_valid 3 cycles after accept, out_result=5, out_rd=1, out_wen=1.
- FWD_EN=1: ADDI x1,x0,5 then ADD x2,x1,x1 (0x00108133) back-to-back -> results 5 then 10 on consecutive cycles, in_ready never drops. FWD_EN=0, same stream -> 10 appears 3 cycles after 5 (two bubbles), in_ready low 2 cycles.
- ADDI x3,x0,-1 (0xFFF00193), then SRAI x4,x3,4, then SRLI x5,x3,28 -> 0xFFFFFFFF, 0xFFFFFFFF, 0x0000000F. SLT vs SLTU of x3 and x1 -> 1 and 0.
- out_ready low 5 cycles with 4 instructions offered -> out_* stable, in_ready falls after 3 accepted. After release, results retire in order with none lost or duplicated.
- ADDI x0,x0,7 then ADD x6,x0,x0 -> 7 with out_wen=0, then 0. Word 0x0000007F -> out_illegal=1, out_result=0. NUM_REGS=16 with rd=x20 -> out_illegal=1.
- Assert rst mid-stream with 3 instructions in flight -> out_valid=0 and in_ready=1 immediately (async). Reading x1 afterwards returns 0.
